// File: rtl/active_list.sv
// In-order active list: allocates at tail, retires done entries from head, rolls squashed entries back youngest-first.
// Latency: alloc_index/commit/rollback are combinational from state; complete is visible as commit one cycle later.
// Backpressure: full stalls decode (also held high during rollback); commit and rollback have no ready.
module active_list #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  alloc_virtual_addr,
  input  logic [REG_ADDR_WIDTH:0]    alloc_physical_addr,
  input  logic [REG_ADDR_WIDTH:0]    alloc_old_physical_addr,
  output logic [FREE_LIST_WIDTH-1:0] alloc_index,
  output logic                       full,
  output logic                       empty,
  output logic [FREE_LIST_WIDTH:0]   count,
  input  logic                       complete_valid,
  input  logic [FREE_LIST_WIDTH-1:0] complete_index,
  output logic                       commit_valid,
  output logic [REG_ADDR_WIDTH-1:0]  commit_virtual_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_physical_addr,
  output logic [REG_ADDR_WIDTH:0]    commit_old_physical_addr,
  input  logic                       flush,
  input  logic [FREE_LIST_WIDTH-1:0] flush_index,
  output logic                       rollback_valid,
  output logic [REG_ADDR_WIDTH-1:0]  rollback_virtual_addr,
  output logic [REG_ADDR_WIDTH:0]    rollback_physical_addr,
  output logic [REG_ADDR_WIDTH:0]    rollback_old_physical_addr
);

  localparam int DEPTH = 1 << FREE_LIST_WIDTH;
  localparam logic [FREE_LIST_WIDTH:0] DEPTH_CNT = {1'b1, {FREE_LIST_WIDTH{1'b0}}};

  typedef logic [FREE_LIST_WIDTH-1:0] idx_t;
  typedef logic [FREE_LIST_WIDTH:0]   cnt_t;
  typedef enum logic {IDLE, ROLLBACK} state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0]          valid_q, done_q, squash;
  logic [REG_ADDR_WIDTH-1:0] virt_q [DEPTH];
  logic [REG_ADDR_WIDTH:0]   phys_q [DEPTH];
  logic [REG_ADDR_WIDTH:0]   old_q  [DEPTH];

  idx_t head, tail, tail_m1, stop_idx, flush_stop;
  cnt_t count_q, count_nxt;
  logic alloc_fire, flush_fire, rb_fire;

  assign tail_m1    = tail - 1'b1;
  assign flush_stop = flush_index + 1'b1;

  assign full         = (count_q == DEPTH_CNT) || (state == ROLLBACK);
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign alloc_index  = tail;
  assign commit_valid = valid_q[head] & done_q[head];

  assign alloc_fire = alloc_valid & ~full & ~flush;
  assign flush_fire = flush & (state == IDLE);
  assign rb_fire    = (state == ROLLBACK);

  assign count_nxt = count_q + cnt_t'(alloc_fire) - cnt_t'(commit_valid) - cnt_t'(rb_fire);

  // Squashed range is (flush_index, tail-1], measured as a modular offset from flush_index+1.
  always_comb begin
    squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_fire && ((idx_t'(i) - flush_stop) < (tail - flush_stop)))
        squash[i] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (flush_fire && (tail != flush_stop)) state_nxt = ROLLBACK;
      ROLLBACK: if (tail_m1 == stop_idx)                state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      stop_idx <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      done_q   <= '0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      if (commit_valid) head <= head + 1'b1;
      if (alloc_fire)   tail <= tail + 1'b1;
      else if (rb_fire) tail <= tail_m1;
      if (flush_fire)   stop_idx <= flush_stop;

      valid_q <= valid_q & ~squash;
      if (commit_valid) valid_q[head] <= 1'b0;
      if (complete_valid && valid_q[complete_index]) done_q[complete_index] <= 1'b1;
      if (alloc_fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
      end
    end
  end

  // Payload needs no reset: outputs are gated by their valid.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      virt_q[tail] <= alloc_virtual_addr;
      phys_q[tail] <= alloc_physical_addr;
      old_q[tail]  <= alloc_old_physical_addr;
    end
  end

  assign commit_virtual_addr      = commit_valid ? virt_q[head] : '0;
  assign commit_physical_addr     = commit_valid ? phys_q[head] : '0;
  assign commit_old_physical_addr = commit_valid ? old_q[head]  : '0;

  assign rollback_valid             = rb_fire;
  assign rollback_virtual_addr      = rb_fire ? virt_q[tail_m1] : '0;
  assign rollback_physical_addr     = rb_fire ? phys_q[tail_m1] : '0;
  assign rollback_old_physical_addr = rb_fire ? old_q[tail_m1]  : '0;

endmodule

// File: tb/tb_active_list.sv
// Directed bench for active_list; commit and rollback streams are checked against scoreboard queues.
module tb_active_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid;
  logic [4:0] alloc_virtual_addr;
  logic [5:0] alloc_physical_addr;
  logic [5:0] alloc_old_physical_addr;
  logic [2:0] alloc_index;
  logic       full, empty;
  logic [3:0] count;
  logic       complete_valid;
  logic [2:0] complete_index;
  logic       commit_valid;
  logic [4:0] commit_virtual_addr;
  logic [5:0] commit_physical_addr;
  logic [5:0] commit_old_physical_addr;
  logic       flush;
  logic [2:0] flush_index;
  logic       rollback_valid;
  logic [4:0] rollback_virtual_addr;
  logic [5:0] rollback_physical_addr;
  logic [5:0] rollback_old_physical_addr;

  typedef logic [16:0] rec_t;  // {virtual, physical, old_physical}
  rec_t sb_commit[$];
  rec_t sb_rb[$];
  rec_t mon_c, mon_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  active_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_virtual_addr(alloc_virtual_addr),
    .alloc_physical_addr(alloc_physical_addr), .alloc_old_physical_addr(alloc_old_physical_addr),
    .alloc_index(alloc_index), .full(full), .empty(empty), .count(count),
    .complete_valid(complete_valid), .complete_index(complete_index),
    .commit_valid(commit_valid), .commit_virtual_addr(commit_virtual_addr),
    .commit_physical_addr(commit_physical_addr), .commit_old_physical_addr(commit_old_physical_addr),
    .flush(flush), .flush_index(flush_index),
    .rollback_valid(rollback_valid), .rollback_virtual_addr(rollback_virtual_addr),
    .rollback_physical_addr(rollback_physical_addr), .rollback_old_physical_addr(rollback_old_physical_addr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input int va, input int pa, input int oa);
    alloc_valid             = v;
    alloc_virtual_addr      = 5'(va);
    alloc_physical_addr     = 6'(pa);
    alloc_old_physical_addr = 6'(oa);
  endtask

  function automatic rec_t mk(input int va, input int pa, input int oa);
    return {5'(va), 6'(pa), 6'(oa)};
  endfunction

  // Monitor: every presented commit/rollback must match the head of its queue.
  always @(negedge clk) begin
    if (commit_valid) begin
      checks++;
      if (sb_commit.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected actual=%h expected=none", {commit_virtual_addr, commit_physical_addr, commit_old_physical_addr});
      end else begin
        mon_c = sb_commit.pop_front();
        if ({commit_virtual_addr, commit_physical_addr, commit_old_physical_addr} != mon_c) begin
          errors++;
          $display("FAIL commit_data actual=%h expected=%h", {commit_virtual_addr, commit_physical_addr, commit_old_physical_addr}, mon_c);
        end
      end
    end
    if (rollback_valid) begin
      checks++;
      if (sb_rb.size() == 0) begin
        errors++;
        $display("FAIL rollback_unexpected actual=%h expected=none", {rollback_virtual_addr, rollback_physical_addr, rollback_old_physical_addr});
      end else begin
        mon_r = sb_rb.pop_front();
        if ({rollback_virtual_addr, rollback_physical_addr, rollback_old_physical_addr} != mon_r) begin
          errors++;
          $display("FAIL rollback_data actual=%h expected=%h", {rollback_virtual_addr, rollback_physical_addr, rollback_old_physical_addr}, mon_r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_alloc(1'b0, 0, 0, 0);
    complete_valid = 1'b0; complete_index = '0;
    flush = 1'b0; flush_index = '0;

    @(negedge clk);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_count", count, 0);
    chk("reset_commit_valid", commit_valid, 0);
    chk("reset_rollback_valid", rollback_valid, 0);
    chk("reset_alloc_index", alloc_index, 0);
    chk("reset_commit_old", commit_old_physical_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill all eight entries, then try a ninth.
    for (int i = 0; i < 8; i++) begin
      set_alloc(1'b1, i + 1, 33 + i, 10 + i);
      @(negedge clk);
      chk("fill_alloc_index", alloc_index, i);
      tick();
    end
    alloc_valid = 1'b0;
    @(negedge clk);
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    tick();
    set_alloc(1'b1, 9, 41, 17);
    @(negedge clk);
    chk("ninth_full", full, 1);
    chk("ninth_alloc_index", alloc_index, 0);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    chk("ninth_count", count, 8);
    chk("ninth_tail", alloc_index, 0);
    tick();

    // Out-of-order complete 2,0,1 with the full/commit/alloc collision folded in.
    complete_valid = 1'b1; complete_index = 3'd2;
    @(negedge clk);
    chk("ooo_no_commit_a", commit_valid, 0);
    tick();
    complete_index = 3'd0;
    sb_commit.push_back(mk(1, 33, 10));
    @(negedge clk);
    chk("ooo_no_commit_b", commit_valid, 0);
    tick();
    complete_valid = 1'b0;
    set_alloc(1'b1, 9, 41, 17);
    @(negedge clk);
    chk("collide_full", full, 1);
    chk("collide_count", count, 8);
    chk("collide_commit", commit_valid, 1);
    tick();
    complete_valid = 1'b1; complete_index = 3'd1;
    sb_commit.push_back(mk(2, 34, 11));
    sb_commit.push_back(mk(3, 35, 12));
    @(negedge clk);
    chk("wrap_alloc_index", alloc_index, 0);
    chk("wrap_full", full, 0);
    chk("wrap_count", count, 7);
    chk("ooo_no_commit_c", commit_valid, 0);
    tick();
    alloc_valid = 1'b0; complete_valid = 1'b0;
    @(negedge clk);
    chk("wrap_count_after", count, 8);
    chk("ooo_commit1", commit_valid, 1);
    tick();
    @(negedge clk);
    chk("ooo_count_7", count, 7);
    chk("ooo_commit2", commit_valid, 1);
    tick();
    @(negedge clk);
    chk("ooo_count_6", count, 6);
    chk("ooo_commit_idle", commit_valid, 0);
    chk("ooo_sb_drained", sb_commit.size(), 0);
    tick();

    rst_n = 1'b0;
    @(negedge clk);
    chk("reset2_empty", empty, 1);
    chk("reset2_count", count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Six entries, flush at index 2 squashes 3..5.
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b1, 17 + i, 50 + i, 2 + i);
      @(negedge clk);
      chk("six_alloc_index", alloc_index, i);
      tick();
    end
    set_alloc(1'b1, 30, 63, 1);
    flush = 1'b1; flush_index = 3'd2;
    sb_rb.push_back(mk(22, 55, 7));
    sb_rb.push_back(mk(21, 54, 6));
    sb_rb.push_back(mk(20, 53, 5));
    @(negedge clk);
    chk("flush_cycle_full", full, 0);
    chk("flush_cycle_rb", rollback_valid, 0);
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_index = 3'd4;
    @(negedge clk);
    chk("rb1_valid", rollback_valid, 1);
    chk("rb1_full", full, 1);
    chk("rb1_count", count, 6);
    tick();
    complete_valid = 1'b0;
    @(negedge clk);
    chk("rb2_full", full, 1);
    chk("rb2_count", count, 5);
    tick();
    @(negedge clk);
    chk("rb3_full", full, 1);
    chk("rb3_count", count, 4);
    tick();
    @(negedge clk);
    chk("rb_done_valid", rollback_valid, 0);
    chk("rb_done_count", count, 3);
    chk("rb_done_full", full, 0);
    chk("rb_done_tail", alloc_index, 3);
    chk("rb_done_no_commit", commit_valid, 0);
    chk("rb_sb_drained", sb_rb.size(), 0);
    tick();

    // Flush of the youngest entry: no rollback at all.
    flush = 1'b1; flush_index = 3'd2;
    @(negedge clk);
    chk("young_flush_rb", rollback_valid, 0);
    tick();
    flush = 1'b0;
    set_alloc(1'b1, 25, 60, 7);
    @(negedge clk);
    chk("young_rb_after", rollback_valid, 0);
    chk("young_alloc_index", alloc_index, 3);
    chk("young_full", full, 0);
    chk("young_count", count, 3);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    chk("young_count_after", count, 4);
    chk("young_tail_after", alloc_index, 4);
    tick();

    // Reset in the second rollback cycle of a three-entry squash.
    flush = 1'b1; flush_index = 3'd0;
    sb_rb.push_back(mk(25, 60, 7));
    sb_rb.push_back(mk(19, 52, 4));
    @(negedge clk);
    chk("rst_flush_rb", rollback_valid, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("rst_rb1_valid", rollback_valid, 1);
    tick();
    rst_n = 1'b0;
    sb_rb.delete();
    @(negedge clk);
    chk("rst_rb_valid", rollback_valid, 0);
    chk("rst_rb_virtual", rollback_virtual_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_alloc_index", alloc_index, 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_rb", rollback_valid, 0);
    tick();

    // Life after reset: allocate, complete, commit.
    set_alloc(1'b1, 3, 40, 9);
    @(negedge clk);
    chk("post_alloc_index", alloc_index, 0);
    tick();
    alloc_valid = 1'b0;
    complete_valid = 1'b1; complete_index = 3'd0;
    sb_commit.push_back(mk(3, 40, 9));
    @(negedge clk);
    chk("post_no_bypass", commit_valid, 0);
    tick();
    complete_valid = 1'b0;
    @(negedge clk);
    chk("post_count", count, 1);
    tick();
    @(negedge clk);
    chk("post_empty", empty, 1);
    chk("final_commit_sb", sb_commit.size(), 0);
    chk("final_rb_sb", sb_rb.size(), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/active_list.md
Name: active_list

Overview:
- In-order active list (reorder buffer) for the renamed pipeline; the allocator/retirer behind `active_list_index` carried through the decode-to-exec register.
- Decode allocates one entry per instruction and receives its index. Writeback marks entries done by index.
- Entries retire in program order, returning each superseded physical register to the free list.
- On branch flush, squashes younger entries and walks them back youngest-first so the rename map and free list are restored.

Parameters:
REG_ADDR_WIDTH, 5, architectural (virtual) register address width; physical addresses are REG_ADDR_WIDTH+1 bits
FREE_LIST_WIDTH, 3, index width; DEPTH = 2**FREE_LIST_WIDTH entries

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  decode requests an entry this cycle
alloc_virtual_addr  in  REG_ADDR_WIDTH  destination architectural register
alloc_physical_addr  in  REG_ADDR_WIDTH+1  newly mapped physical register
alloc_old_physical_addr  in  REG_ADDR_WIDTH+1  previous mapping of that register
alloc_index  out  FREE_LIST_WIDTH  index granted (= tail), combinational
full  out  1  allocation refused (stall decode)
empty  out  1  no occupied entries
count  out  FREE_LIST_WIDTH+1  occupied entries (head..tail)
complete_valid  in  1  writeback marks an entry done
complete_index  in  FREE_LIST_WIDTH  entry to mark
commit_valid  out  1  head entry retires this cycle
commit_virtual_addr  out  REG_ADDR_WIDTH  head entry field
commit_physical_addr  out  REG_ADDR_WIDTH+1  head entry field
commit_old_physical_addr  out  REG_ADDR_WIDTH+1  register to free
flush  in  1  mispredicted branch; squash all entries younger than flush_index
flush_index  in  FREE_LIST_WIDTH  active-list index of the branch (must be occupied)
rollback_valid  out  1  a squashed entry is being undone this cycle
rollback_virtual_addr  out  REG_ADDR_WIDTH  restore map[virtual] to old physical
rollback_physical_addr  out  REG_ADDR_WIDTH+1  return to free list
rollback_old_physical_addr  out  REG_ADDR_WIDTH+1  mapping to restore

Behaviour:
- **Storage:** circular buffer of DEPTH entries. Each entry holds {valid, done, virtual, physical, old_physical}. Pointers are head, tail and a count register.
- **Reset:** head = tail = 0, count = 0, all valid/done bits = 0, FSM = IDLE. Outputs: empty = 1, full = 0, commit_valid = 0, rollback_valid = 0, all address outputs 0.
- **full:** = (count == DEPTH) || state == ROLLBACK. Computed from the current count only; a same-cycle commit does not free the slot for allocation.
- **Allocate:** on alloc_valid && !full && !flush, at the clock edge:
  - write the entry at tail with valid = 1, done = 0;
  - tail <= tail + 1 (mod DEPTH);
  - alloc_index = tail, combinational in the same cycle.
  - Requests while full are dropped; decode holds them.
- **Complete:** sets done[complete_index] if valid[complete_index]; otherwise ignored. Completing the head entry makes commit_valid high on the next cycle (no bypass).
- **Commit:** commit_valid = valid[head] && done[head], combinational, with the commit_* outputs taken from the head entry.
  - On the edge: clear valid[head], head <= head + 1, count decrements.
  - There is no ready; the consumer always accepts.
  - At most one commit per cycle.
- **Simultaneous allocate and commit:** count unchanged.
- **FSM IDLE, on flush:**
  - clear the valid bits of every entry strictly after flush_index up to tail-1; data is kept;
  - ignore alloc that cycle;
  - complete and commit still apply to entries that remain valid.
  - If tail == flush_index + 1 (no younger entries), stay IDLE. Otherwise go to ROLLBACK.
- **FSM ROLLBACK, each cycle:**
  - rollback_valid = 1; rollback_* outputs = data at tail-1 (youngest first);
  - on the edge: tail <= tail - 1, count decrements (net with any commit);
  - when the new tail == flush_index + 1, return to IDLE, captured into a register at flush.
  - Example: 3 squashed entries produce 3 rollback cycles, then IDLE.
- **During ROLLBACK:**
  - flush is ignored (control guarantees none);
  - complete to squashed indices is ignored (valid = 0);
  - commits of older entries continue. Head can never pass a squashed entry, since it is invalid.
- **Wrap-around:** all index arithmetic is mod DEPTH. full vs empty is distinguished by count, not by pointer equality.
- **Reset mid-ROLLBACK:** returns immediately to the reset state; no further rollback outputs.

Test Plan:
1. **Fill:** reset, then allocate 8 entries with virtual 1..8, physical 33..40. Required: alloc_index 0..7, full = 1 and count = 8 after the 8th; a 9th request is refused with tail unchanged.
2. **Out-of-order complete:** complete indices 2, 0, 1. Required: commits occur on the cycles after index 0 and then index 1 complete, then index 2, in order 0, 1, 2, with commit_old_physical_addr from each entry; no commit while done[head] = 0.
3. **Simultaneous events:** at count = 8, commit head while alloc_valid = 1. Required: alloc refused, count = 7. Next cycle alloc accepted at index 0 (wrap), count = 8.
4. **Flush with rollback:** entries 0..5 occupied, flush_index = 2. Required:
   - rollback_valid for 3 cycles with virtual of entries 5, 4, 3;
   - full = 1 throughout;
   - then tail = 3, count = 3, IDLE;
   - complete_index = 4 during rollback has no effect.
5. **Flush of the youngest entry:** flush_index = tail-1. Required: no rollback cycles, tail unchanged, alloc on the next cycle returns index = tail.
6. **Reset mid-rollback:** rst_n low during rollback cycle 2. Required: outputs immediately return to reset values, count = 0, empty = 1.
